// File: rtl/dtc_share_arb.sv
// Round-robin time-sharing of one combinational decision-tree classifier among NUM_REQ requesters.
// Optional build macro DTC_ARB_STATS_EN adds a saturating completed-response counter (stat_count).
module dtc_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 5,
   parameter int OUT_W   = 5,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   output logic [IN_W-1:0]         cls_inp,
   input  logic [OUT_W-1:0]        cls_outp,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [OUT_W-1:0]        rsp_data,
   output logic [ID_W-1:0]         rsp_id
`ifdef DTC_ARB_STATS_EN
   ,
   output logic [15:0]             stat_count
`endif
);

   typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] win;
   logic [ID_W-1:0] nxt_ptr;
   logic [ID_W:0]   cand;
   logic            found;
   logic [IN_W-1:0] sel_data;

   // Search from rr_ptr upward; cand carries one extra bit so the modulo wrap works for any NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ))
            cand = cand - (ID_W+1)'(NUM_REQ);
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found = 1'b1;
            win   = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (ID_W'(j) == win)
            sel_data = req_data[j*IN_W +: IN_W];
      end
   end

   always_comb begin
      req_ready = '0;
      if (!rst && state == IDLE && found)
         req_ready = NUM_REQ'(1) << win;
   end

   assign nxt_ptr = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         gnt_id    <= '0;
         cls_inp   <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cls_inp <= sel_data;
                  gnt_id  <= win;
                  state   <= EVAL;
               end
            end
            EVAL: begin
               rsp_data  <= cls_outp;
               rsp_id    <= gnt_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= nxt_ptr;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DTC_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         stat_count <= '0;
      else if (rsp_valid && rsp_ready && stat_count != 16'hFFFF)
         stat_count <= stat_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_dtc_share_arb.sv
// Directed bench for dtc_share_arb: classifier modelled as ~cls_inp, responses checked by a scoreboard monitor.
module tb_dtc_share_arb;

   localparam int NUM_REQ = 4;
   localparam int IN_W    = 5;
   localparam int OUT_W   = 5;
   localparam int ID_W    = 2;

   logic                    clk;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*IN_W-1:0] req_data;
   logic [IN_W-1:0]         cls_inp;
   logic [OUT_W-1:0]        cls_outp;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [OUT_W-1:0]        rsp_data;
   logic [ID_W-1:0]         rsp_id;
`ifdef DTC_ARB_STATS_EN
   logic [15:0]             stat_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [ID_W+OUT_W-1:0] sb_q[$];

   dtc_share_arb #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .cls_inp   (cls_inp),
      .cls_outp  (cls_outp),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
`ifdef DTC_ARB_STATS_EN
      ,
      .stat_count(stat_count)
`endif
   );

   assign cls_outp = ~cls_inp;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [IN_W-1:0] v);
      req_data[i*IN_W +: IN_W] = v;
   endtask

   function automatic logic [ID_W+OUT_W-1:0] exp_rsp(input logic [ID_W-1:0] id, input logic [IN_W-1:0] d);
      return {id, ~d};
   endfunction

   // Monitor: every completed handshake must match the oldest expected response.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", {25'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
         end else begin
            chk("rsp", {25'd0, rsp_id, rsp_data}, {25'd0, sb_q.pop_front()});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [IN_W-1:0] D0 = 5'b00011;
   localparam logic [IN_W-1:0] D1 = 5'b01100;
   localparam logic [IN_W-1:0] D2 = 5'b10001;
   localparam logic [IN_W-1:0] D3 = 5'b11110;

   initial begin
      logic [NUM_REQ-1:0] exp_rdy;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_cls_inp", {27'd0, cls_inp}, 32'd0);
      chk("rst_rsp_data", {27'd0, rsp_data}, 32'd0);
      chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
`ifdef DTC_ARB_STATS_EN
      chk("rst_stat", {16'd0, stat_count}, 32'd0);
`endif
      tick();
      rst = 1'b0;

      // Single request from requester 2
      req_valid = 4'b0100;
      set_data(2, 5'b01010);
      sb_q.push_back(exp_rsp(2'd2, 5'b01010));
      @(negedge clk);
      chk("single_ready", {28'd0, req_ready}, 32'h4);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("single_ready_eval", {28'd0, req_ready}, 32'h0);
      chk("single_cls_inp", {27'd0, cls_inp}, 32'h0A);
      chk("single_valid_eval", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("single_valid", {31'd0, rsp_valid}, 32'd1);
      chk("single_data", {27'd0, rsp_data}, 32'h15);
      chk("single_id", {30'd0, rsp_id}, 32'd2);
      tick();

      // Reset restores rr_ptr to 0 before the round-robin sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_data(0, D0);
      set_data(1, D1);
      set_data(2, D2);
      set_data(3, D3);
      req_valid = 4'b1111;
      sb_q.push_back(exp_rsp(2'd0, D0));
      sb_q.push_back(exp_rsp(2'd1, D1));
      sb_q.push_back(exp_rsp(2'd2, D2));
      sb_q.push_back(exp_rsp(2'd3, D3));
      sb_q.push_back(exp_rsp(2'd0, D0));
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         exp_rdy = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
         chk($sformatf("rr_ready_c%0d", c), {28'd0, req_ready}, {28'd0, exp_rdy});
`ifdef DTC_ARB_STATS_EN
         if (c == 12) chk("rr_stat4", {16'd0, stat_count}, 32'd4);
`endif
         if (c == 12) begin
            tick();
            req_valid = '0;
         end
      end
      tick();

      // Backpressure on a grant to requester 3, with requesters 1 and 2 queued behind it
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      sb_q.push_back(exp_rsp(2'd3, D3));
      @(negedge clk);
      chk("bp_ready", {28'd0, req_ready}, 32'h8);
      tick();
      req_valid = 4'b0110;
      sb_q.push_back(exp_rsp(2'd1, D1));
      sb_q.push_back(exp_rsp(2'd2, D2));
      tick();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp_data_%0d", c), {27'd0, rsp_data}, 32'h01);
         chk($sformatf("bp_id_%0d", c), {30'd0, rsp_id}, 32'd3);
         chk($sformatf("bp_ready_%0d", c), {28'd0, req_ready}, 32'h0);
      end
      tick();
      rsp_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("wrap_skip_1", {28'd0, req_ready}, 32'h2);
      tick();
      req_valid = 4'b0100;
      @(negedge clk);
      chk("wrap_eval_ready", {28'd0, req_ready}, 32'h0);
      tick();
      tick();
      @(negedge clk);
      chk("wrap_skip_2", {28'd0, req_ready}, 32'h4);
      tick();
      req_valid = '0;
      tick();
      tick();

      // Mid-operation reset: rr_ptr is 3 here, so grant 0 is aborted in EVAL
      req_valid = 4'b0001;
      @(negedge clk);
      chk("abort_ready", {28'd0, req_ready}, 32'h1);
      tick();
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cls_eval", {27'd0, cls_inp}, {27'd0, D0});
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_cls_inp", {27'd0, cls_inp}, 32'd0);
`ifdef DTC_ARB_STATS_EN
      chk("abort_stat", {16'd0, stat_count}, 32'd0);
`endif
      tick();
      // rr_ptr back at 0 means requester 0 wins over 3
      req_valid = 4'b1001;
      sb_q.push_back(exp_rsp(2'd0, D0));
      @(negedge clk);
      chk("abort_rr_ptr0", {28'd0, req_ready}, 32'h1);
      tick();
      req_valid = '0;
      repeat (6) tick();
      @(negedge clk);
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
